// File: rtl/soc_system_v5_pulse_out_if.sv
// Avalon-MM slave bus bundle for the pulse-capable output PIO.
interface soc_system_v5_pulse_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_v5_pulse_out.sv
// Output PIO with masked auto-clear pulse timer (down-counter, expiry at count 1).
// Build option: define PIO_OUT_IRQ_EN to drive irq from the done flag; otherwise irq is tied 0.
//
//  state     | meaning
//  ST_IDLE   | no pulse in flight, counter idle
//  ST_BUSY   | pulse armed, counter decrementing toward expiry
module soc_system_v5_pulse_out #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    soc_system_v5_pulse_out_if.slave  bus,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic                      irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_MASK   = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_OUTSET = 3'd3;
    localparam logic [2:0] A_OUTCLR = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [0:0]            state_q, state_d;
    logic                  done_q, done_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  wr, rd, busy, expire, arm;
    logic [DATA_WIDTH-1:0] wd_data, data_exp;
    logic [CNT_WIDTH-1:0]  wd_len;
    logic                  unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign rd        = bus.chipselect &  bus.write_n;
    assign wd_data   = bus.writedata[DATA_WIDTH-1:0];
    assign wd_len    = bus.writedata[CNT_WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    assign busy     = (state_q == ST_BUSY);
    assign expire   = busy && (cnt_q == CNT_WIDTH'(1));
    // Expiry clear is applied first so a same-edge bus write lands on top of it.
    assign data_exp = expire ? (data_q & ~mask_q) : data_q;

    always_comb begin
        data_d  = data_exp;
        mask_d  = mask_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        arm     = 1'b0;

        if (busy) begin
            if (expire) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end

        if (wr) begin
            case (bus.address)
                A_DATA:   data_d = wd_data;
                A_MASK:   mask_d = wd_data;
                A_LEN:    len_d  = wd_len;
                A_OUTSET: data_d = data_exp | wd_data;
                A_OUTCLR: data_d = data_exp & ~wd_data;
                A_STATUS: if (bus.writedata[1] && !expire) done_d = 1'b0;
                default:  ;
            endcase
            // Retrigger: a qualifying write always reloads, even mid-pulse or at expiry.
            arm = ((bus.address == A_DATA) || (bus.address == A_OUTSET)) &&
                  ((data_d & mask_q & wd_data) != '0) && (len_q != '0);
            if (arm) begin
                cnt_d   = len_q;
                state_d = ST_BUSY;
            end
        end else if (rd) begin
            case (bus.address)
                A_DATA:   rdata_d = 32'(data_q);
                A_MASK:   rdata_d = 32'(mask_q);
                A_LEN:    rdata_d = 32'(len_q);
                A_STATUS: rdata_d = {30'd0, done_q, busy};
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            mask_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port     = data_q;
    assign bus.readdata = rdata_q;

`ifdef PIO_OUT_IRQ_EN
    assign irq = done_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_v5_pulse_out.sv
// Scoreboard bench: driver pushes per-edge expectations from a deadline-based model; monitor compares.
module tb_soc_system_v5_pulse_out;
    localparam int DW = 10;
    localparam int CW = 16;
    localparam logic [31:0] DMASK = (32'd1 << DW) - 32'd1;
    localparam logic [31:0] LMASK = (32'd1 << CW) - 32'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] out_port;
    logic          irq;

    soc_system_v5_pulse_out_if bus ();

    soc_system_v5_pulse_out #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] rd;
        logic [31:0] outp;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int tag_n = 0;

    // Reference state: a pulse is described by the absolute edge at which it ends.
    logic [31:0] m_data, m_mask, m_len, m_rd;
    bit          m_busy, m_done;
    int          m_deadline;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s edge=%0d actual=0x%0h required=0x%0h", name, tag, act, exp_v);
        end
    endtask

    task automatic model(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                         input logic [31:0] wd, input int t);
        logic [31:0] rdv;
        logic [31:0] w;
        bit expd;
        if (rst) begin
            m_data = 0; m_mask = 0; m_len = 0; m_rd = 0;
            m_busy = 0; m_done = 0; m_deadline = 0;
            return;
        end
        w = wd & DMASK;
        case (a)
            3'd0:    rdv = m_data;
            3'd1:    rdv = m_mask;
            3'd2:    rdv = m_len;
            3'd5:    rdv = {30'd0, m_done, m_busy};
            default: rdv = 0;
        endcase
        expd = m_busy && (t == m_deadline);
        if (expd) begin
            m_data = m_data & ~m_mask;
            m_busy = 0;
            m_done = 1;
        end
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = w;
                3'd1: m_mask = w;
                3'd2: m_len = wd & LMASK;
                3'd3: m_data = m_data | w;
                3'd4: m_data = m_data & ~w;
                3'd5: if (wd[1] && !expd) m_done = 0;
                default: ;
            endcase
            if ((a == 3'd0 || a == 3'd3) && ((m_data & m_mask & w) != 0) && (m_len != 0)) begin
                m_busy = 1;
                m_deadline = t + int'(m_len);
            end
        end else if (cs && wn) begin
            m_rd = rdv;
        end
    endtask

    task automatic op(input bit rst, input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] wd);
        exp_t e;
        reset          = rst;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        model(rst, cs, wn, a, wd, tag_n);
        e.tag  = tag_n;
        e.rd   = m_rd;
        e.outp = m_data;
`ifdef PIO_OUT_IRQ_EN
        e.irq  = m_done;
`else
        e.irq  = 1'b0;
`endif
        sb.push_back(e);
        tag_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        op(0, 1, 0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        op(0, 1, 1, a, $urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, $urandom_range(0, 1), 3'($urandom), $urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].tag == edge_cnt - 1) begin
                e = sb.pop_front();
                chk("out_port", e.tag, 32'(out_port), e.outp);
                chk("readdata", e.tag, bus.readdata, e.rd);
                chk("irq", e.tag, 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin : driver
        // T1 reset, then STATUS read
        op(1, 0, 1, 3'd0, 0);
        op(1, 0, 1, 3'd0, 0);
        rd(3'd5);
        idle(1);
        // T2 DATA write with junk in upper bits, read back
        wr(3'd0, 32'hABCD_E2A5);
        rd(3'd0);
        idle(1);
        // T3 single pulse, STATUS, W1C
        wr(3'd1, 32'h001);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'h001);
        idle(7);
        rd(3'd5);
        wr(3'd5, 32'h2);
        rd(3'd5);
        // T4 retrigger after 6 clocks
        wr(3'd2, 32'd10);
        wr(3'd3, 32'h001);
        idle(5);
        wr(3'd3, 32'h001);
        idle(12);
        rd(3'd5);
        wr(3'd5, 32'h2);
        // T5 auto-clear disabled, then OUTCLR
        wr(3'd2, 32'd0);
        wr(3'd1, 32'h3FF);
        wr(3'd0, 32'h3FF);
        idle(20);
        rd(3'd5);
        wr(3'd4, 32'h0F0);
        rd(3'd0);
        // T6 reset mid-pulse
        wr(3'd2, 32'd8);
        wr(3'd1, 32'h001);
        wr(3'd0, 32'h000);
        wr(3'd3, 32'h001);
        idle(2);
        op(1, 0, 1, 3'd0, 0);
        idle(12);
        rd(3'd5);
        // W1C coinciding with expiry, then re-arm coinciding with expiry
        wr(3'd1, 32'h003);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'h001);
        idle(2);
        wr(3'd5, 32'h2);
        rd(3'd5);
        wr(3'd3, 32'h002);
        idle(2);
        wr(3'd3, 32'h001);
        rd(3'd5);
        idle(4);
        // LEN=1 boundary and mask change while busy
        wr(3'd2, 32'd1);
        wr(3'd3, 32'h003);
        idle(2);
        wr(3'd2, 32'd6);
        wr(3'd0, 32'h3FF);
        wr(3'd1, 32'h0F0);
        idle(7);
        rd(3'd0);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom);
            wd = $urandom;
            if (a == 3'd2) wd = {wd[31:16], 16'($urandom_range(0, 12))};
            if ($urandom_range(0, 299) == 0)
                op(1, 0, 1, a, wd);
            else if ($urandom_range(0, 99) < 30)
                op(0, 0, $urandom_range(0, 1), a, wd);
            else
                op(0, 1, $urandom_range(0, 1), a, wd);
        end
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
